// File: rtl/slow_dac_slew.sv
// Time-multiplexed slew-rate limiter for the 16-channel slow DAC.
// One shared subtract/compare datapath visits one channel per clock each update period.
module slow_dac_slew #(
  parameter int unsigned NCH = 16,
  parameter int unsigned DIV = 1000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               load,
  input  logic        [15:0] step,
  input  logic signed [15:0] target [0:NCH-1],
  output logic signed [15:0] sout   [0:NCH-1],
  output logic     [NCH-1:0] settled,
  output logic               sweep_done
);

  localparam int unsigned CW = $clog2(DIV);
  localparam int unsigned IW = $clog2(NCH);

  if (DIV <= NCH + 2) begin : g_div_check
    $error("slow_dac_slew: DIV must be greater than NCH+2");
  end

  typedef enum logic [1:0] {
    IDLE,
    SWEEP,
    DONE
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            done_q, done_d;
  logic [15:0]     sout_q [NCH];
  logic [15:0]     sout_d [NCH];
  logic [NCH-1:0]  settled_q, settled_d;

  logic            tick;
  logic [15:0]     cur_s, cur_t, new_val;
  logic [16:0]     diff, mag;
  logic            new_set;

  // Shared channel datapath; 17-bit difference so full-scale swings never overflow.
  always_comb begin
    cur_s   = sout_q[idx_q];
    cur_t   = target[idx_q];
    diff    = {cur_t[15], cur_t} - {cur_s[15], cur_s};
    mag     = diff[16] ? (~diff + 17'd1) : diff;
    new_val = cur_s;
    new_set = 1'b0;
    if (mag <= {1'b0, step}) begin
      new_val = cur_t;
      new_set = 1'b1;
    end else if (!diff[16]) begin
      new_val = cur_s + step;
    end else begin
      new_val = cur_s - step;
    end
  end

  always_comb begin
    tick      = en && (cnt_q == CW'(DIV - 1));
    cnt_d     = cnt_q;
    state_d   = state_q;
    idx_d     = idx_q;
    done_d    = 1'b0;
    sout_d    = sout_q;
    settled_d = settled_q;

    if (en) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (tick) begin
          state_d = SWEEP;
          idx_d   = '0;
        end
      end
      SWEEP: begin
        sout_d[idx_q]    = new_val;
        settled_d[idx_q] = new_set;
        if (idx_q == IW'(NCH - 1)) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // load overrides everything, including a tick or sweep completion in the same cycle
    if (load) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        sout_d[i] = target[i];
      end
      settled_d = '1;
      cnt_d     = '0;
      state_d   = IDLE;
      idx_d     = '0;
      done_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      done_q    <= 1'b0;
      settled_q <= '0;
      for (int unsigned i = 0; i < NCH; i++) begin
        sout_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      done_q    <= done_d;
      settled_q <= settled_d;
      for (int unsigned i = 0; i < NCH; i++) begin
        sout_q[i] <= sout_d[i];
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NCH; i++) begin
      sout[i] = signed'(sout_q[i]);
    end
  end

  assign settled    = settled_q;
  assign sweep_done = done_q;

endmodule

// File: tb/tb_slow_dac_slew.sv
// Self-checking bench for slow_dac_slew: directed timing sequences, a vector table
// and randomized sweeps compared against a per-sweep arithmetic model.
module tb_slow_dac_slew;

  localparam int NCH = 16;
  localparam int DIV = 1000;

  logic               clk = 1'b0;
  logic               rst;
  logic               en;
  logic               load;
  logic        [15:0] step;
  logic signed [15:0] target [0:NCH-1];
  logic signed [15:0] sout   [0:NCH-1];
  logic     [NCH-1:0] settled;
  logic               sweep_done;

  int vectors     = 0;
  int miscompares = 0;

  slow_dac_slew #(.NCH(NCH), .DIV(DIV)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .load       (load),
    .step       (step),
    .target     (target),
    .sout       (sout),
    .settled    (settled),
    .sweep_done (sweep_done)
  );

  always #5 clk = ~clk;

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    int ch;
    int s0;
    int tgt;
    int stp;
    int exp_s;
    int exp_set;
  } vec_t;

  vec_t tbl [11];

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Advance on falling edges until sweep_done is seen; n = edges advanced.
  task automatic wait_done(input int budget, input string name, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sweep_done && n < budget);
    vectors++;
    if (!sweep_done) begin
      miscompares++;
      $display("FAIL %s: no sweep_done within %0d cycles, got 0, expected 1", name, n);
    end
  endtask

  task automatic set_all(input logic signed [15:0] v);
    for (int i = 0; i < NCH; i++) target[i] = v;
  endtask

  // Reference rule for one channel over one update period.
  function automatic int slew(input int s, input int t, input int stp, output bit set);
    int d;
    d = t - s;
    if (d <= stp && -d <= stp) begin
      set = 1'b1;
      return t;
    end
    set = 1'b0;
    return (d > 0) ? s + stp : s - stp;
  endfunction

  int            n, m, cnt, nz;
  int            m_s [NCH];
  bit [NCH-1:0]  m_set;
  bit            b;
  int            exp3 [4];

  initial begin
    tbl[0]  = '{0,       0,   1000,   300,    300, 0};
    tbl[1]  = '{1,     300,   1000,   300,    600, 0};
    tbl[2]  = '{2,     900,   1000,   300,   1000, 1};
    tbl[3]  = '{3,   32767, -32768, 65535, -32768, 1};
    tbl[4]  = '{4,  -32768,  32767, 65535,  32767, 1};
    tbl[5]  = '{5,     100,   -100,     0,    100, 0};
    tbl[6]  = '{6,      55,     55,     0,     55, 1};
    tbl[7]  = '{7,  -32768,  32767,  1000, -31768, 0};
    tbl[8]  = '{8,   32767, -32768, 40000,  -7233, 0};
    tbl[9]  = '{9,       0,    -50,    50,    -50, 1};
    tbl[10] = '{15,      0,     51,    50,     50, 0};
    exp3    = '{300, 600, 900, 1000};

    rst = 1'b0; en = 1'b0; load = 1'b0; step = '0;
    set_all(16'sd0);
    repeat (3) @(negedge clk);
    for (int i = 0; i < NCH; i++) check($sformatf("reset_sout%0d", i), int'(sout[i]), 0);
    check("reset_settled", int'(settled), 0);
    check("reset_done", int'(sweep_done), 0);

    // All-zero targets: outputs stay put, every channel reports settled.
    rst = 1'b1; en = 1'b1; step = 16'd100;
    wait_done(1100, "first_sweep", n);
    check("zero_settled", int'(settled), 32'hFFFF);
    nz = 0;
    for (int i = 0; i < NCH; i++) if (sout[i] !== 16'sd0) nz++;
    check("zero_sout_nonzero_count", nz, 0);
    wait_done(1100, "period", n);
    check("sweep_period", n, DIV);

    // Ramp on channel 3.
    target[3] = 16'sd1000; step = 16'd300;
    for (int k = 0; k < 4; k++) begin
      wait_done(1100, "ramp", n);
      check($sformatf("ramp_sout3_%0d", k), int'(sout[3]), exp3[k]);
      check($sformatf("ramp_settled3_%0d", k), int'(settled[3]), (k == 3) ? 1 : 0);
      check($sformatf("ramp_sout2_%0d", k), int'(sout[2]), 0);
    end

    // Load during channel 7 of a sweep aborts it and restarts the divider.
    step = 16'd1; set_all(16'sh1234);
    repeat (991) @(negedge clk);
    check("mid_sout6", int'(sout[6]), 1);
    check("mid_sout7", int'(sout[7]), 0);
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    nz = 0;
    for (int i = 0; i < NCH; i++) if (sout[i] !== 16'sh1234) nz++;
    check("load_sout_wrong_count", nz, 0);
    check("load_settled", int'(settled), 32'hFFFF);
    check("load_no_done", int'(sweep_done), 0);
    wait_done(1100, "after_load", m);
    check("load_to_done_cycles", m + 1, DIV + NCH + 1);

    // Target change at index 10: later channel picks it up, earlier one does not.
    step = 16'd1000; set_all(16'sd0); load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (1010) @(negedge clk);
    target[15] = 16'sd500; target[9] = 16'sd500;
    wait_done(1100, "midchange", n);
    check("midchange_cycles", n, 6);
    check("midchange_sout15", int'(sout[15]), 500);
    check("midchange_settled15", int'(settled[15]), 1);
    check("midchange_sout9", int'(sout[9]), 0);
    check("midchange_settled9", int'(settled[9]), 1);
    wait_done(1100, "midchange_next", n);
    check("midchange_next_sout9", int'(sout[9]), 500);

    // en dropped at index 5: sweep still completes, then divider holds.
    repeat (989) @(negedge clk);
    en = 1'b0;
    wait_done(1100, "en_off_finish", n);
    check("en_off_finish_cycles", n, 11);
    cnt = 0;
    repeat (1500) begin
      @(negedge clk);
      if (sweep_done) cnt++;
    end
    check("en_off_no_sweeps", cnt, 0);
    en = 1'b1;
    wait_done(1100, "en_resume", n);
    check("en_resume_cycles", n, DIV - 6 + NCH + 1);

    // Asynchronous reset in the middle of a sweep.
    step = 16'd1; set_all(16'sh0F0F);
    repeat (992) @(negedge clk);
    check("pre_rst_sout0", int'(sout[0]), 1);
    #2 rst = 1'b0;
    #1;
    check("async_rst_sout0", int'(sout[0]), 0);
    check("async_rst_sout15", int'(sout[15]), 0);
    check("async_rst_settled", int'(settled), 0);
    check("async_rst_done", int'(sweep_done), 0);
    @(negedge clk);
    rst = 1'b1;
    wait_done(1100, "post_rst", n);
    check("post_rst_cycles", n, DIV + NCH);

    // Vector table: preload via load, retarget, one sweep.
    for (int v = 0; v < 11; v++) begin
      set_all(16'sd0);
      target[tbl[v].ch] = 16'(tbl[v].s0);
      load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      target[tbl[v].ch] = 16'(tbl[v].tgt);
      step = 16'(tbl[v].stp);
      wait_done(1100, $sformatf("tbl%0d", v), n);
      check($sformatf("tbl%0d_sout", v), int'(sout[tbl[v].ch]), tbl[v].exp_s);
      check($sformatf("tbl%0d_settled", v), int'(settled[tbl[v].ch]), tbl[v].exp_set);
    end

    // Randomized sweeps against the arithmetic model.
    for (int it = 0; it < 16; it++) begin
      for (int i = 0; i < NCH; i++) target[i] = 16'($urandom);
      case ($urandom_range(0, 3))
        0:       step = 16'd0;
        1:       step = 16'($urandom_range(1, 200));
        2:       step = 16'($urandom_range(0, 65535));
        default: step = 16'hFFFF;
      endcase
      if (it == 0 || $urandom_range(0, 3) == 0) begin
        load = 1'b1;
        for (int i = 0; i < NCH; i++) m_s[i] = int'(target[i]);
        m_set = '1;
        @(negedge clk);
        load = 1'b0;
        nz = 0;
        for (int i = 0; i < NCH; i++) if (int'(sout[i]) != m_s[i]) nz++;
        check($sformatf("rnd%0d_load_wrong_count", it), nz, 0);
        for (int i = 0; i < NCH; i++) target[i] = 16'($urandom);
      end
      wait_done(1100, $sformatf("rnd%0d", it), n);
      for (int i = 0; i < NCH; i++) begin
        m_s[i]   = slew(m_s[i], int'(target[i]), int'(step), b);
        m_set[i] = b;
        check($sformatf("rnd%0d_sout%0d", it, i), int'(sout[i]), m_s[i]);
      end
      check($sformatf("rnd%0d_settled", it), int'(settled), int'(m_set));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/slow_dac_slew.md
Name: slow_dac_slew

Overview:
- Time-multiplexed slew-rate limiter that sits directly upstream of the slow-DAC driver.
- Produces the 16 signed 16-bit setpoints (sout0..sout15) consumed by the dual-LTC2666 SPI stage.
- Each output moves toward its commanded target by at most STEP codes per update period. Large setpoint jumps from the servo/host logic therefore never reach the DAC pins as steps.
- One shared adder/comparator processes channels sequentially, one per clock.

Parameters:
- NCH, 16: number of channels. Fixed at 16 to match the downstream driver.
- DIV, 1000: update period in clk cycles. Must be greater than NCH+2; elaboration error otherwise.

Ports:
- clk  input  1  system clock; same clock as the slow-DAC driver.
- rst  input  1  asynchronous, active-low reset.
- en  input  1  enables the update-period divider.
- load  input  1  single-cycle pulse; all outputs jump immediately to their targets.
- step  input  16  unsigned maximum change per update, in codes.
- target  input  16 signed x [0:NCH-1]  commanded setpoints (unpacked array).
- sout  output  16 signed x [0:NCH-1]  slew-limited setpoints to the DAC driver.
- settled  output  NCH  bit i = 1 when sout[i] equals target[i] at its last evaluation.
- sweep_done  output  1  single-cycle pulse after the last channel of a sweep is written.

Behaviour:
- Reset (rst=0, asynchronous):
  - all sout = 0, settled = 0, sweep_done = 0.
  - divider count = 0, state = IDLE, channel index = 0.
- Divider:
  - While en=1 it counts 0..DIV-1 and wraps.
  - The wrap cycle raises an internal tick.
  - While en=0 the count holds. A sweep already in progress still completes.
- State machine has three states: IDLE, SWEEP, DONE.
  - IDLE -> SWEEP on tick; index = 0.
  - SWEEP: one channel per cycle, index i = 0..NCH-1. After i = NCH-1 -> DONE.
  - DONE: sweep_done = 1 for exactly one cycle -> IDLE.
  - A sweep takes NCH+1 cycles. DIV > NCH+2 guarantees no tick arrives outside IDLE. Any tick that does arrive outside IDLE is ignored.
- Per-channel update in SWEEP, registered and visible the next cycle:
  - diff = target[i] - sout[i], computed at 17-bit signed width with no overflow.
  - If |diff| <= step: sout[i] = target[i], settled[i] = 1.
  - Else if diff > 0: sout[i] = sout[i] + step, settled[i] = 0.
  - Else: sout[i] = sout[i] - step, settled[i] = 0.
  - The result stays within [target, old sout], so it never wraps past -32768 or 32767.
  - target[i] and step are sampled in the cycle channel i is processed. Changes mid-sweep affect only channels not yet processed.
  - step = 0: outputs frozen; settled[i] = 1 only if already equal.
  - step >= 65535: behaves as an immediate copy per sweep.
- load = 1, in any state:
  - Next cycle: every sout = target, settled = all 1s.
  - Divider count = 0, state = IDLE; any sweep in progress is aborted without a sweep_done pulse.
  - load has priority over tick in the same cycle.
- Outputs are registers only; no combinational path from inputs to sout.
- Reset asserted mid-sweep: immediate return to the reset values above. Sweeps resume on the first tick after release.

Test Plan:
- Reset, then en=1, step=100, all targets 0 -> sout stays 0. settled = 16'hFFFF after the first sweep_done. sweep_done period is 1000 cycles.
- target[3] = 1000, step = 300 -> sout[3] takes 300, 600, 900, 1000 on successive sweeps. settled[3] is 0, 0, 0, 1. Other channels are untouched.
- target[0] = -32768 from sout[0] = 32767, step = 65535 -> sout[0] = -32768 after one sweep with no wrap. Same for 32767 from -32768.
- load pulse with targets 16'sh1234 on all channels, mid-sweep at index 7 -> next cycle all sout = 16'sh1234, settled = 16'hFFFF. No sweep_done for the aborted sweep. The next tick comes 1000 cycles later.
- en=0 asserted during a sweep at index 5 -> that sweep completes and sweep_done fires. No further sweeps occur while en=0. Re-enabling resumes the count from its held value.
- Change target[15] from 0 to 500 while a sweep is at index 10, step = 1000 -> sout[15] = 500 at the end of that same sweep.
